dma_rd_channel: RTL

- Engine-side end of the DMA read channel: accepts rd_addr/rd_size/rd_go from an AFU and issues in-order cache-line read requests to a host memory request port.
- Buffers the returned lines in an internal FIFO and presents them to the AFU through the empty/rd_data/rd_en consumer handshake.
- Asserts rd_done once the AFU has consumed rd_size lines.
- Sits between the AFU's dma read port and the host memory adapter.

---
 rtl/dma_rd_channel.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dma_rd_channel.sv
// DMA read channel, engine side: issues in-order cache-line reads and buffers the returned lines in a FWFT FIFO.
// Optional `DMA_RD_CHANNEL_ERR_EN adds a sticky err output for spurious responses and pops of an empty buffer.
module dma_rd_channel #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 43,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_go,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-7:0] req_addr,
    input  logic                  req_ready,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data
`ifdef DMA_RD_CHANNEL_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int LINE_W = ADDR_WIDTH - 6;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SUM_W  = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [LINE_W-1:0]     line_addr;
    logic [SIZE_WIDTH-1:0] size, issued, consumed;
    logic [SIZE_WIDTH-1:0] issued_nxt, consumed_nxt;
    logic [CNT_W-1:0]      outstanding, fifo_count;
    logic [CNT_W-1:0]      out_nxt, cnt_nxt;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  start, accept, push, pop, has_credit;
    logic                  unused_addr_bits;

    assign unused_addr_bits = &{1'b0, rd_addr[5:0]};

    assign start  = rd_go && (state == IDLE || state == DONE);
    assign accept = req_valid && req_ready;
    // A response with nothing outstanding (e.g. left over from before a reset) is dropped.
    assign push   = rsp_valid && (outstanding != '0);
    assign pop    = rd_en && !empty;

    assign issued_nxt   = start ? '0 : issued + SIZE_WIDTH'(accept);
    assign consumed_nxt = start ? '0 : consumed + SIZE_WIDTH'(pop);
    assign out_nxt      = start ? '0 : outstanding + CNT_W'(accept) - CNT_W'(push);
    assign cnt_nxt      = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Credit uses next-cycle counts so a registered req_valid can never over-commit the FIFO.
    assign has_credit = (SUM_W'(out_nxt) + SUM_W'(cnt_nxt)) < SUM_W'(FIFO_DEPTH);

    assign empty   = (fifo_count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            line_addr   <= '0;
            size        <= '0;
            issued      <= '0;
            consumed    <= '0;
            outstanding <= '0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            rd_done     <= 1'b0;
        end else begin
            issued      <= issued_nxt;
            consumed    <= consumed_nxt;
            outstanding <= out_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        line_addr <= rd_addr[ADDR_WIDTH-1:6];
                        size      <= rd_size;
                        req_addr  <= rd_addr[ADDR_WIDTH-1:6];
                        if (rd_size == '0) begin
                            state     <= DONE;
                            rd_done   <= 1'b1;
                            req_valid <= 1'b0;
                        end else begin
                            state     <= ISSUE;
                            rd_done   <= 1'b0;
                            req_valid <= has_credit;
                        end
                    end
                end
                ISSUE: begin
                    if (consumed_nxt == size) begin
                        state     <= DONE;
                        rd_done   <= 1'b1;
                        req_valid <= 1'b0;
                    end else if (issued_nxt == size) begin
                        state     <= DRAIN;
                        req_valid <= 1'b0;
                    end else begin
                        req_valid <= has_credit;
                        req_addr  <= line_addr + LINE_W'(issued_nxt);
                    end
                end
                DRAIN: begin
                    if (consumed_nxt == size) begin
                        state   <= DONE;
                        rd_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= cnt_nxt;
        end
    end

    // NOTE: the storage array has no reset; a flushed FIFO is defined by its pointers and rd_data is gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rsp_data;
    end

`ifdef DMA_RD_CHANNEL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= (start ? 1'b0 : err)
                           | (rsp_valid && outstanding == '0)
                           | (rd_en && empty);
    end
`endif

endmodule
